// File: rtl/mem_bus_if.sv
// mem_bus_if: cache-side master for the asynchronous off-chip memory
// handshake bus. Turns one cache request into a burst read, a word write,
// or a word write followed by a burst read, and owns the cache side of the
// shared 16-bit tristate data bus.
module mem_bus_if #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rd,
  input  logic        req_alloc,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        fill_valid,
  output logic [1:0]  fill_idx,
  output logic [15:0] fill_data,
  output logic        done,
  output logic        timeout_err,
  output logic        rrqst,
  output logic        wrqst,
  output logic        rdacpt,
  input  logic        rrdy,
  input  logic        rdrdy,
  input  logic        wacpt,
  inout  wire  [15:0] data
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [3:0] {
    IDLE, R_ADDR, R_WAIT, R_ACK, R_REL, W_ADDR, W_GAP, W_DATA, W_END, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          alloc_q, alloc_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmoErr_q, tmoErr_d;
  logic          oe_q, oe_d;
  logic          fillValid_q, fillValid_d;
  logic [1:0]    fillIdx_q, fillIdx_d;
  logic [15:0]   fillData_q, fillData_d;

  logic [SYNC_STAGES-1:0] rrdySync_q, rdrdySync_q, wacptSync_q;
  logic rrdy_s, rdrdy_s, wacpt_s;
  logic [15:0] driveVal;

  assign rrdy_s  = rrdySync_q[SYNC_STAGES-1];
  assign rdrdy_s = rdrdySync_q[SYNC_STAGES-1];
  assign wacpt_s = wacptSync_q[SYNC_STAGES-1];

  // Bring the memory's asynchronous acknowledges into the cache clock domain
  always_ff @(posedge clock) begin
    if (reset) begin
      rrdySync_q  <= '0;
      rdrdySync_q <= '0;
      wacptSync_q <= '0;
    end else begin
      rrdySync_q  <= {rrdySync_q[SYNC_STAGES-2:0], rrdy};
      rdrdySync_q <= {rdrdySync_q[SYNC_STAGES-2:0], rdrdy};
      wacptSync_q <= {wacptSync_q[SYNC_STAGES-2:0], wacpt};
    end
  end

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      alloc_q     <= 1'b0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      tmoErr_q    <= 1'b0;
      oe_q        <= 1'b0;
      fillValid_q <= 1'b0;
      fillIdx_q   <= '0;
      fillData_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      alloc_q     <= alloc_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      tmoErr_q    <= tmoErr_d;
      oe_q        <= oe_d;
      fillValid_q <= fillValid_d;
      fillIdx_q   <= fillIdx_d;
      fillData_q  <= fillData_d;
    end
  end

  // Next-state logic: act only on the acknowledge edge awaited in this state
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    alloc_d     = alloc_q;
    cnt_d       = cnt_q;
    tmoErr_d    = (state_q == DONE) ? 1'b0 : tmoErr_q;
    fillValid_d = 1'b0;
    fillIdx_d   = fillIdx_q;
    fillData_d  = fillData_q;
    case (state_q)
      IDLE: if (req_valid) begin
        addr_d   = req_addr;
        wdata_d  = req_wdata;
        alloc_d  = req_alloc & ~req_rd;
        cnt_d    = '0;
        tmoErr_d = 1'b0;
        state_d  = req_rd ? R_ADDR : W_ADDR;
      end
      R_ADDR: if (rrdy_s) state_d = R_WAIT;
      R_WAIT: if (rdrdy_s) begin
        state_d     = R_ACK;
        fillValid_d = 1'b1;
        fillIdx_d   = cnt_q;
        fillData_d  = data;
      end
      R_ACK:  if (!rdrdy_s) state_d = R_REL;
      R_REL: begin
        if (cnt_q == 2'd3) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + 2'd1;
          state_d = R_WAIT;
        end
      end
      W_ADDR: if (wacpt_s) state_d = W_GAP;
      W_GAP:  if (!wacpt_s) state_d = W_DATA;
      W_DATA: if (wacpt_s) state_d = W_END;
      W_END: begin
        if (alloc_q) begin
          cnt_d   = '0;
          state_d = R_WAIT;
        end else if (!wacpt_s) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && state_q != DONE && state_d == state_q &&
        tmo_q == TW'(TIMEOUT_CYC - 1)) begin
      state_d  = DONE;
      tmoErr_d = 1'b1;
    end
    tmo_d = (state_d != state_q || state_q == IDLE || state_q == DONE) ?
            '0 : tmo_q + TW'(1);
    oe_d  = (state_d == R_ADDR || state_d == W_ADDR || state_d == W_DATA);
  end

  // Moore outputs decoded from the current state
  always_comb begin
    req_ready   = (state_q == IDLE);
    rrqst       = (state_q == R_ADDR) || (state_q == W_ADDR && alloc_q);
    wrqst       = (state_q == W_ADDR) || (state_q == W_DATA);
    rdacpt      = (state_q == R_ACK);
    done        = (state_q == DONE);
    timeout_err = (state_q == DONE) && tmoErr_q;
    fill_valid  = fillValid_q;
    fill_idx    = fillIdx_q;
    fill_data   = fillData_q;
    driveVal    = (state_q == W_DATA) ? wdata_q : addr_q;
  end

  assign data = (oe_q && !rdrdy_s) ? driveVal : 16'hzzzz;

endmodule
